// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-address generator with prioritised next-PC selection and redirect epochs
module pc_gen #(
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
    parameter int unsigned       INST_BYTES = 4,
    parameter int unsigned       FETCH_N    = 1,
    parameter int unsigned       EPOCH_W    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_i,
    input  logic               flush_vld_i,
    input  logic [ADDR_W-1:0]  flush_addr_i,
    input  logic               br_vld_i,
    input  logic [ADDR_W-1:0]  br_addr_i,
    input  logic               pred_vld_i,
    input  logic [ADDR_W-1:0]  pred_addr_i,
    output logic               req_vld_o,
    output logic [ADDR_W-1:0]  req_addr_o,
    output logic [EPOCH_W-1:0] req_epoch_o,
    input  logic               req_rdy_i,
    output logic               misalign_o
);

    // Low address bits that must be zero for an instruction-aligned target.
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INST_BYTES - 1);
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(INST_BYTES * FETCH_N);

    typedef enum logic {
        BOOT,
        RUN
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [EPOCH_W-1:0]   epoch_q, epoch_d;
    logic                 misalign_q, misalign_d;
    logic                 fire;
    logic                 load_tgt;
    logic                 bump_epoch;
    logic [ADDR_W-1:0]    tgt;

    assign req_vld_o   = (state_q == RUN);
    assign req_addr_o  = pc_q;
    assign req_epoch_o = epoch_q;
    assign misalign_o  = misalign_q;
    assign fire        = req_vld_o & req_rdy_i & ~stall_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VEC;
            epoch_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epoch_q    <= epoch_d;
            misalign_q <= misalign_d;
        end
    end

    // Flush and branch redirects ignore stall/ready so they are never lost;
    // prediction and sequential advance only happen on an accepted request.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epoch_d    = epoch_q;
        misalign_d = 1'b0;
        load_tgt   = 1'b0;
        bump_epoch = 1'b0;
        tgt        = '0;

        if (state_q == BOOT) begin
            state_d = RUN;
        end else if (flush_vld_i) begin
            tgt        = flush_addr_i;
            load_tgt   = 1'b1;
            bump_epoch = 1'b1;
        end else if (br_vld_i) begin
            tgt        = br_addr_i;
            load_tgt   = 1'b1;
            bump_epoch = 1'b1;
        end else if (fire && pred_vld_i) begin
            tgt      = pred_addr_i;
            load_tgt = 1'b1;
        end else if (fire) begin
            pc_d = pc_q + STEP;
        end

        if (load_tgt) begin
            pc_d       = tgt & ~LOW_MASK;
            misalign_d = |(tgt & LOW_MASK);
        end
        if (bump_epoch) begin
            epoch_d = epoch_q + EPOCH_W'(1);
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - table-driven self-checking bench for pc_gen
module tb_pc_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, fv, bv, pv, rdy;
    logic [31:0] fa, ba, pa;
    logic        vld, mis;
    logic [31:0] addr;
    logic [1:0]  ep;

    logic        rst2, stall2, rdy2, zero_bit;
    logic [31:0] zero_addr;
    logic        vld2, mis2;
    logic [31:0] addr2;
    logic [1:0]  ep2;

    pc_gen #(.ADDR_W(32), .RESET_VEC(32'h1000), .INST_BYTES(4), .FETCH_N(1), .EPOCH_W(2)) dut (
        .clk(clk), .rst(rst), .stall_i(stall),
        .flush_vld_i(fv), .flush_addr_i(fa),
        .br_vld_i(bv), .br_addr_i(ba),
        .pred_vld_i(pv), .pred_addr_i(pa),
        .req_vld_o(vld), .req_addr_o(addr), .req_epoch_o(ep),
        .req_rdy_i(rdy), .misalign_o(mis)
    );

    pc_gen #(.ADDR_W(32), .RESET_VEC(32'h0), .INST_BYTES(4), .FETCH_N(2), .EPOCH_W(2)) dut2 (
        .clk(clk), .rst(rst2), .stall_i(stall2),
        .flush_vld_i(zero_bit), .flush_addr_i(zero_addr),
        .br_vld_i(zero_bit), .br_addr_i(zero_addr),
        .pred_vld_i(zero_bit), .pred_addr_i(zero_addr),
        .req_vld_o(vld2), .req_addr_o(addr2), .req_epoch_o(ep2),
        .req_rdy_i(rdy2), .misalign_o(mis2)
    );

    typedef struct {
        logic        rst, stall, fv;
        logic [31:0] fa;
        logic        bv;
        logic [31:0] ba;
        logic        pv;
        logic [31:0] pa;
        logic        rdy;
        logic        e_vld;
        logic [31:0] e_addr;
        logic [1:0]  e_ep;
        logic        e_mis;
    } vec_t;

    typedef struct {
        logic        vld;
        logic [31:0] addr;
        logic [1:0]  ep;
        logic        mis;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic vec_t mk(input logic r, input logic s, input logic f_v, input logic [31:0] f_a,
                                input logic b_v, input logic [31:0] b_a, input logic p_v,
                                input logic [31:0] p_a, input logic rd, input logic e_v,
                                input logic [31:0] e_a, input logic [1:0] e_e, input logic e_m);
        vec_t v;
        v.rst = r; v.stall = s; v.fv = f_v; v.fa = f_a; v.bv = b_v; v.ba = b_a;
        v.pv = p_v; v.pa = p_a; v.rdy = rd;
        v.e_vld = e_v; v.e_addr = e_a; v.e_ep = e_e; v.e_mis = e_m;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, req);
    endtask

    task automatic step2(input int idx, input logic s, input logic [31:0] e_addr);
        exp_t e;
        stall2 = s;
        exp_q.push_back('{vld: 1'b1, addr: e_addr, ep: 2'd0, mis: 1'b0});
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        chk("n2_vld", idx, {31'd0, vld2}, {31'd0, e.vld});
        chk("n2_addr", idx, addr2, e.addr);
    endtask

    initial begin
        exp_t e;
        rst = 1'b1; stall = 1'b0; fv = 1'b0; bv = 1'b0; pv = 1'b0; rdy = 1'b0;
        fa = '0; ba = '0; pa = '0;
        rst2 = 1'b1; stall2 = 1'b0; rdy2 = 1'b0; zero_bit = 1'b0; zero_addr = '0;

        //                rst s  fv fa            bv ba            pv pa          rdy  vld addr          ep mis
        tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,      1,   0, 32'h1000,     0, 0));
        tbl.push_back(mk(1, 0, 0, 32'h0,        1, 32'h5000,     0, 32'h0,      1,   0, 32'h1000,     0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'h5000,     0, 32'h0,      1,   1, 32'h1000,     0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,      1,   1, 32'h1004,     0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,      1,   1, 32'h1008,     0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,      1,   1, 32'h100C,     0, 0));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,      1,   1, 32'h100C,     0, 0));
        tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'h2000,     0, 32'h0,      0,   1, 32'h2000,     1, 0));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,      0,   1, 32'h2000,     1, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,      1,   1, 32'h2004,     1, 0));
        tbl.push_back(mk(0, 0, 1, 32'h80,       1, 32'h400,      1, 32'h5000,   1,   1, 32'h80,       2, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h3006,   1,   1, 32'h3004,     2, 1));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h7000,   0,   1, 32'h3004,     2, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,      1,   1, 32'h3008,     2, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'hFFFFFFFC, 0, 32'h0,      0,   1, 32'hFFFFFFFC, 3, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,      1,   1, 32'h0,        3, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'h10,       0, 32'h0,      1,   1, 32'h10,       0, 0));
        tbl.push_back(mk(0, 0, 1, 32'h21,       0, 32'h0,        0, 32'h0,      0,   1, 32'h20,       1, 1));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,      0,   1, 32'h20,       1, 0));
        tbl.push_back(mk(0, 0, 1, 32'h40,       1, 32'h33,       0, 32'h0,      1,   1, 32'h40,       2, 0));
        tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,      1,   0, 32'h1000,     0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,      1,   1, 32'h1000,     0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,      1,   1, 32'h1004,     0, 0));

        @(negedge clk);
        foreach (tbl[i]) begin
            rst = tbl[i].rst; stall = tbl[i].stall; rdy = tbl[i].rdy;
            fv = tbl[i].fv; fa = tbl[i].fa; bv = tbl[i].bv; ba = tbl[i].ba;
            pv = tbl[i].pv; pa = tbl[i].pa;
            exp_q.push_back('{vld: tbl[i].e_vld, addr: tbl[i].e_addr, ep: tbl[i].e_ep, mis: tbl[i].e_mis});
            @(posedge clk);
            @(negedge clk);
            e = exp_q.pop_front();
            chk("vld", i, {31'd0, vld}, {31'd0, e.vld});
            chk("addr", i, addr, e.addr);
            chk("epoch", i, {30'd0, ep}, {30'd0, e.ep});
            chk("misalign", i, {31'd0, mis}, {31'd0, e.mis});
        end

        // FETCH_N=2 instance: held in reset so far, then stall toggling
        chk("n2_reset_vld", 0, {31'd0, vld2}, 32'd0);
        chk("n2_reset_addr", 0, addr2, 32'h0);
        rst2 = 1'b0; rdy2 = 1'b1;
        step2(0, 1'b0, 32'h0);
        step2(1, 1'b1, 32'h0);
        step2(2, 1'b0, 32'h8);
        step2(3, 1'b1, 32'h8);
        step2(4, 1'b0, 32'h10);
        chk("n2_epoch", 5, {30'd0, ep2}, 32'd0);
        chk("n2_misalign", 5, {31'd0, mis2}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised fetch-address generator: the next generation of the pipeline PC register.
- Drives instruction-fetch requests to the I-side memory interface over a valid/ready handshake.
- Arbitrates four next-PC sources by priority: exception flush, resolved branch, predictor target, sequential.
- Tags each request with a redirect epoch so the fetch stage can discard stale responses. Redirects are never lost while the pipeline is stalled.

Parameters:
- ADDR_W, 32, width of PC and all target addresses.
- RESET_VEC, 32'h00000000, first fetch address after reset.
- INST_BYTES, 4, bytes per instruction; power of two, >= 1.
- FETCH_N, 1, instructions per fetch group; sequential step = INST_BYTES*FETCH_N.
- EPOCH_W, 2, width of the redirect epoch counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- stall_i  in  1  pipeline stall from control; blocks request acceptance
- flush_vld_i  in  1  exception/interrupt redirect
- flush_addr_i  in  ADDR_W  exception target
- br_vld_i  in  1  resolved-branch redirect (mispredict or taken branch)
- br_addr_i  in  ADDR_W  branch target
- pred_vld_i  in  1  predictor says the current req_addr_o group is predicted-taken
- pred_addr_i  in  ADDR_W  predicted target
- req_vld_o  out  1  fetch request valid
- req_addr_o  out  ADDR_W  fetch address (equals internal PC)
- req_epoch_o  out  EPOCH_W  epoch attached to the request
- req_rdy_i  in  1  memory accepts request
- misalign_o  out  1  one-cycle pulse: a redirect target had nonzero low bits

Behaviour:
- Reset is synchronous, active-high, on clk. While rst=1 and on the first cycle after deassert:
  - pc=RESET_VEC, req_vld_o=0, epoch=0, misalign_o=0.
  - States: BOOT (entered on reset) -> RUN on the first clk edge with rst=0. RUN is never left except by reset.
- In RUN, req_vld_o=1 continuously. Fire = req_vld_o & req_rdy_i & ~stall_i.
- Next-PC selection, evaluated each cycle in RUN, first match wins:
  1. flush_vld_i: pc<=flush_addr_i; epoch<=epoch+1. Applied regardless of stall_i/req_rdy_i.
  2. br_vld_i: pc<=br_addr_i; epoch<=epoch+1. Applied regardless of stall_i/req_rdy_i.
  3. fire & pred_vld_i: pc<=pred_addr_i; epoch unchanged.
  4. fire: pc<=pc+INST_BYTES*FETCH_N; epoch unchanged.
  5. otherwise: pc and epoch hold.
- Simultaneous events:
  - flush and branch in the same cycle: flush wins; branch is discarded, not queued; epoch increments by 1 only.
  - Redirect in the same cycle as a fire: the fired request was issued with the old epoch; the new pc appears next cycle with the new epoch.
- Handshake:
  - req_addr_o/req_epoch_o stay stable while req_vld_o=1 and not fired, except when a flush or branch redirect occurs.
  - A redirect replaces an unaccepted request. The memory side must not rely on address stability across an epoch change.
- Alignment: redirect and prediction targets have their low log2(INST_BYTES) bits forced to 0 before loading. If any forced bit was 1, misalign_o=1 for the following cycle only. Only the winning source is checked.
- Arithmetic: sequential increment wraps modulo 2^ADDR_W (e.g. all-ones-aligned + step -> low address, no flag). Epoch wraps modulo 2^EPOCH_W.
- Latency: a redirect asserted in cycle N is visible on req_addr_o in cycle N+1. Redirects in BOOT are ignored.
- Reset mid-operation: any pending request is dropped. req_vld_o=0 on the cycle after rst is sampled high. pc returns to RESET_VEC and epoch to 0.

Test Plan:
- Reset with RESET_VEC=32'h1000, req_rdy_i=1 held for 4 cycles after release -> req_vld_o=0 in the BOOT cycle, then addrs 1000,1004,1008,100C, epoch 0 throughout.
- FETCH_N=2, INST_BYTES=4, stall_i toggling 1,0,1,0 -> pc advances by 8 only on the unstalled cycles; the address holds while stalled.
- stall_i=1 and req_rdy_i=0, br_vld_i=1, br_addr_i=32'h2000 -> next cycle req_addr_o=2000, epoch 0->1; after the stall releases the fetch proceeds from 2000 (redirect not lost).
- flush_vld_i and br_vld_i both set in the same cycle (flush 32'h80, branch 32'h400) -> req_addr_o=80, epoch increments once; pred_vld_i in that cycle ignored.
- pred_vld_i=1, pred_addr_i=32'h3006 on a fire -> req_addr_o=3004, misalign_o pulses 1 cycle; without a fire (req_rdy_i=0) the prediction has no effect.
- pc=32'hFFFFFFFC, fire -> pc=0, no misalign; epoch at 3 plus a branch redirect -> epoch 0.
